mem_sequencer: RTL and testbench

Time-slot sequencer sharing the single external SRAM between video fetch, the CPU and the host bridge. Each 16-clock frame (1 µs at 16 MHz) is split into four 4-clock slots: video RAM fetch, character ROM fetch, CPU access and host access. It generates `video_ram_strobe`/`video_rom_strobe` for the video generator and the 1 MHz CPU clock enable. It sits between the video generator, CPU core, host bridge and SRAM pins.

---
 rtl/mem_seq_pkg.sv | 32 +++
 rtl/mem_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_mem_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mem_seq_pkg.sv
// Shared constants for the SRAM time-slot sequencer: slot owners, slot and
// phase indices, and the SRAM windows used by the video fetches.
package mem_seq_pkg;

  typedef enum logic [2:0] {
    OWN_NONE = 3'd0,
    OWN_VRAM = 3'd1,
    OWN_CROM = 3'd2,
    OWN_CPU  = 3'd3,
    OWN_HOST = 3'd4
  } owner_e;

  localparam logic [1:0] SLOT_VRAM = 2'd0;
  localparam logic [1:0] SLOT_CROM = 2'd1;
  localparam logic [1:0] SLOT_CPU  = 2'd2;
  localparam logic [1:0] SLOT_HOST = 2'd3;

  localparam logic [1:0] C0 = 2'd0;
  localparam logic [1:0] C1 = 2'd1;
  localparam logic [1:0] C2 = 2'd2;
  localparam logic [1:0] C3 = 2'd3;

  localparam logic [16:0] VRAM_BASE = 17'h08000;
  localparam logic [16:0] CROM_BASE = 17'h10000;

  // Video windows are 2 KB; bit 11 of the video address only picks the slot.
  function automatic logic [16:0] video_map(input logic [16:0] base,
                                            input logic [11:0] addr);
    return base | {6'd0, addr[10:0]};
  endfunction

endpackage

// File: rtl/mem_sequencer.sv
// Shares one SRAM between video fetch, CPU and host in a 16-clock frame of
// four 4-clock slots; all outputs registered, inputs latched at the end of c0.
module mem_sequencer
  import mem_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        video_en,
  input  logic [11:0] video_addr,
  output logic [7:0]  video_data,
  output logic        video_ram_strobe,
  output logic        video_rom_strobe,
  input  logic        cpu_halt,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_clk_en,
  input  logic        host_req,
  input  logic [16:0] host_addr,
  input  logic        host_we,
  input  logic [7:0]  host_wdata,
  output logic        host_ack,
  output logic [7:0]  host_rdata,
  output logic [16:0] ram_addr,
  output logic [7:0]  ram_data_out,
  output logic        ram_data_oe,
  input  logic [7:0]  ram_data_in,
  output logic        ram_oe_n,
  output logic        ram_we_n
);

  logic        run_q, run_d;
  logic [3:0]  count_q, count_d;
  logic        vid_en_q, vid_en_d;
  owner_e      owner_q, owner_d, owner_sel;
  logic        we_q, we_d;
  logic [16:0] ram_addr_q, ram_addr_d;
  logic [7:0]  ram_data_out_q, ram_data_out_d;
  logic        ram_data_oe_q, ram_data_oe_d;
  logic        ram_oe_n_q, ram_oe_n_d;
  logic        ram_we_n_q, ram_we_n_d;
  logic        vram_stb_q, vram_stb_d;
  logic        crom_stb_q, crom_stb_d;
  logic        cpu_clk_en_q, cpu_clk_en_d;
  logic        host_ack_q, host_ack_d;
  logic [7:0]  video_data_q, video_data_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic [7:0]  host_rdata_q, host_rdata_d;

  logic        end_c0, end_c2;
  logic [1:0]  phase_d, slot_d;
  logic        rd_d, wr_d;

  always_comb begin
    owner_sel = OWN_NONE;
    case (count_q[3:2])
      SLOT_VRAM: owner_sel = vid_en_q ? OWN_VRAM : (host_req ? OWN_HOST : OWN_NONE);
      SLOT_CROM: owner_sel = vid_en_q ? OWN_CROM : (host_req ? OWN_HOST : OWN_NONE);
      SLOT_CPU:  owner_sel = !cpu_halt ? OWN_CPU : (host_req ? OWN_HOST : OWN_NONE);
      default:   owner_sel = host_req ? OWN_HOST : OWN_NONE;
    endcase
  end

  always_comb begin
    // The first edge after reset only arms the counter, so it lands on c0.
    run_d   = 1'b1;
    count_d = run_q ? count_q + 4'd1 : 4'd0;
    phase_d = count_d[1:0];
    slot_d  = count_d[3:2];
    end_c0  = run_q && (count_q[1:0] == C0);
    end_c2  = run_q && (count_q[1:0] == C2);

    vid_en_d = (count_d == 4'd0) ? video_en : vid_en_q;

    owner_d        = owner_q;
    we_d           = we_q;
    ram_addr_d     = ram_addr_q;
    ram_data_out_d = ram_data_out_q;
    if (end_c0) begin
      owner_d = owner_sel;
      we_d    = 1'b0;
      case (owner_sel)
        OWN_VRAM: ram_addr_d = video_map(VRAM_BASE, video_addr);
        OWN_CROM: ram_addr_d = video_map(CROM_BASE, video_addr);
        OWN_CPU: begin
          ram_addr_d = {1'b0, cpu_addr};
          we_d       = cpu_we;
          if (cpu_we) ram_data_out_d = cpu_wdata;
        end
        OWN_HOST: begin
          ram_addr_d = host_addr;
          we_d       = host_we;
          if (host_we) ram_data_out_d = host_wdata;
        end
        default: ;
      endcase
    end else if (phase_d == C0) begin
      owner_d = OWN_NONE;
      we_d    = 1'b0;
    end

    rd_d = (owner_d != OWN_NONE) && !we_d;
    wr_d = (owner_d != OWN_NONE) && we_d;

    ram_oe_n_d    = !(rd_d && ((phase_d == C1) || (phase_d == C2)));
    ram_we_n_d    = !(wr_d && (phase_d == C2));
    ram_data_oe_d = wr_d && (phase_d != C0);
    cpu_clk_en_d  = (owner_d == OWN_CPU) && (phase_d == C3);
    host_ack_d    = (owner_d == OWN_HOST) && (phase_d == C3);

    vram_stb_d = vid_en_d && (slot_d == SLOT_VRAM);
    crom_stb_d = vid_en_d && (slot_d == SLOT_CROM);

    video_data_d = video_data_q;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;
    if (end_c2 && !we_q) begin
      case (owner_q)
        OWN_VRAM, OWN_CROM: video_data_d = ram_data_in;
        OWN_CPU:            cpu_rdata_d  = ram_data_in;
        OWN_HOST:           host_rdata_d = ram_data_in;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q          <= 1'b0;
      count_q        <= 4'd0;
      vid_en_q       <= 1'b0;
      owner_q        <= OWN_NONE;
      we_q           <= 1'b0;
      ram_addr_q     <= 17'd0;
      ram_data_out_q <= 8'd0;
      ram_data_oe_q  <= 1'b0;
      ram_oe_n_q     <= 1'b1;
      ram_we_n_q     <= 1'b1;
      vram_stb_q     <= 1'b0;
      crom_stb_q     <= 1'b0;
      cpu_clk_en_q   <= 1'b0;
      host_ack_q     <= 1'b0;
      video_data_q   <= 8'd0;
      cpu_rdata_q    <= 8'd0;
      host_rdata_q   <= 8'd0;
    end else begin
      run_q          <= run_d;
      count_q        <= count_d;
      vid_en_q       <= vid_en_d;
      owner_q        <= owner_d;
      we_q           <= we_d;
      ram_addr_q     <= ram_addr_d;
      ram_data_out_q <= ram_data_out_d;
      ram_data_oe_q  <= ram_data_oe_d;
      ram_oe_n_q     <= ram_oe_n_d;
      ram_we_n_q     <= ram_we_n_d;
      vram_stb_q     <= vram_stb_d;
      crom_stb_q     <= crom_stb_d;
      cpu_clk_en_q   <= cpu_clk_en_d;
      host_ack_q     <= host_ack_d;
      video_data_q   <= video_data_d;
      cpu_rdata_q    <= cpu_rdata_d;
      host_rdata_q   <= host_rdata_d;
    end
  end

  assign ram_addr         = ram_addr_q;
  assign ram_data_out     = ram_data_out_q;
  assign ram_data_oe      = ram_data_oe_q;
  assign ram_oe_n         = ram_oe_n_q;
  assign ram_we_n         = ram_we_n_q;
  assign video_ram_strobe = vram_stb_q;
  assign video_rom_strobe = crom_stb_q;
  assign cpu_clk_en       = cpu_clk_en_q;
  assign host_ack         = host_ack_q;
  assign video_data       = video_data_q;
  assign cpu_rdata        = cpu_rdata_q;
  assign host_rdata       = host_rdata_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer: a per-clock table for the first frame,
// then whole-frame pulse/strobe masks and a reset-during-write sequence.
module tb_mem_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        video_en = 1'b1;
  logic [11:0] video_addr = 12'h005;
  logic [7:0]  video_data;
  logic        video_ram_strobe, video_rom_strobe;
  logic        cpu_halt = 1'b0;
  logic [15:0] cpu_addr = 16'h1234;
  logic        cpu_we = 1'b1;
  logic [7:0]  cpu_wdata = 8'h5A;
  logic [7:0]  cpu_rdata;
  logic        cpu_clk_en;
  logic        host_req = 1'b1;
  logic [16:0] host_addr = 17'h1ABCD;
  logic        host_we = 1'b0;
  logic [7:0]  host_wdata = 8'hC9;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic [16:0] ram_addr;
  logic [7:0]  ram_data_out;
  logic        ram_data_oe;
  logic [7:0]  ram_data_in = 8'h00;
  logic        ram_oe_n, ram_we_n;

  int total = 0;
  int bad = 0;

  mem_sequencer dut (
    .clk(clk), .reset(reset),
    .video_en(video_en), .video_addr(video_addr), .video_data(video_data),
    .video_ram_strobe(video_ram_strobe), .video_rom_strobe(video_rom_strobe),
    .cpu_halt(cpu_halt), .cpu_addr(cpu_addr), .cpu_we(cpu_we),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_clk_en(cpu_clk_en),
    .host_req(host_req), .host_addr(host_addr), .host_we(host_we),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .ram_addr(ram_addr), .ram_data_out(ram_data_out), .ram_data_oe(ram_data_oe),
    .ram_data_in(ram_data_in), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  // {addr, dout, oe_n, we_n, doe, rs, cs, cen, ack, vdata, hrdata}
  typedef struct {
    logic [11:0] vaddr;
    logic [7:0]  rdin;
    logic [47:0] exp;
  } vec_t;

  vec_t vec [16];

  function automatic vec_t mk(input logic [11:0] va, input logic [7:0] rd,
                              input logic [16:0] a, input logic [7:0] dout,
                              input logic [6:0] ctl, input logic [7:0] vd,
                              input logic [7:0] hr);
    vec_t v;
    v.vaddr = va;
    v.rdin  = rd;
    v.exp   = {a, dout, ctl, vd, hr};
    return v;
  endfunction

  function automatic logic [47:0] obs();
    return {ram_addr, ram_data_out, ram_oe_n, ram_we_n, ram_data_oe,
            video_ram_strobe, video_rom_strobe, cpu_clk_en, host_ack,
            video_data, host_rdata};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic run_frame(input string nm, input logic ven_mid, input logic [7:0] rdin,
                           input logic [15:0] e_rs, input logic [15:0] e_cs,
                           input logic [15:0] e_cen, input logic [15:0] e_ack,
                           input logic [15:0] e_oe, input logic [15:0] e_we);
    logic [15:0] m_rs, m_cs, m_cen, m_ack, m_oe, m_we;
    m_rs = '0; m_cs = '0; m_cen = '0; m_ack = '0; m_oe = '0; m_we = '0;
    ram_data_in = rdin;
    for (int p = 0; p < 16; p++) begin
      @(posedge clk); #1;
      m_rs[p]  = video_ram_strobe;
      m_cs[p]  = video_rom_strobe;
      m_cen[p] = cpu_clk_en;
      m_ack[p] = host_ack;
      m_oe[p]  = !ram_oe_n;
      m_we[p]  = !ram_we_n;
      if (p == 5) video_en = ven_mid;
    end
    chk({nm, " ram_strobe"}, 64'(m_rs), 64'(e_rs));
    chk({nm, " rom_strobe"}, 64'(m_cs), 64'(e_cs));
    chk({nm, " cpu_clk_en"}, 64'(m_cen), 64'(e_cen));
    chk({nm, " host_ack"},   64'(m_ack), 64'(e_ack));
    chk({nm, " oe_active"},  64'(m_oe), 64'(e_oe));
    chk({nm, " we_active"},  64'(m_we), 64'(e_we));
  endtask

  initial begin
    logic any_pulse;

    // ctl bits: oe_n we_n doe rs cs cen ack
    vec[0]  = mk(12'h005, 8'h00, 17'h00000, 8'h00, 7'b1101000, 8'h00, 8'h00);
    vec[1]  = mk(12'h005, 8'h00, 17'h08005, 8'h00, 7'b0101000, 8'h00, 8'h00);
    vec[2]  = mk(12'h005, 8'hA5, 17'h08005, 8'h00, 7'b0101000, 8'h00, 8'h00);
    vec[3]  = mk(12'h005, 8'h00, 17'h08005, 8'h00, 7'b1101000, 8'hA5, 8'h00);
    vec[4]  = mk(12'h83F, 8'h00, 17'h08005, 8'h00, 7'b1100100, 8'hA5, 8'h00);
    vec[5]  = mk(12'h83F, 8'h00, 17'h1003F, 8'h00, 7'b0100100, 8'hA5, 8'h00);
    vec[6]  = mk(12'h83F, 8'h77, 17'h1003F, 8'h00, 7'b0100100, 8'hA5, 8'h00);
    vec[7]  = mk(12'h83F, 8'h00, 17'h1003F, 8'h00, 7'b1100100, 8'h77, 8'h00);
    vec[8]  = mk(12'h83F, 8'h00, 17'h1003F, 8'h00, 7'b1100000, 8'h77, 8'h00);
    vec[9]  = mk(12'h83F, 8'h00, 17'h01234, 8'h5A, 7'b1110000, 8'h77, 8'h00);
    vec[10] = mk(12'h83F, 8'hEE, 17'h01234, 8'h5A, 7'b1010000, 8'h77, 8'h00);
    vec[11] = mk(12'h83F, 8'h00, 17'h01234, 8'h5A, 7'b1110010, 8'h77, 8'h00);
    vec[12] = mk(12'h83F, 8'h00, 17'h01234, 8'h5A, 7'b1100000, 8'h77, 8'h00);
    vec[13] = mk(12'h83F, 8'h00, 17'h1ABCD, 8'h5A, 7'b0100000, 8'h77, 8'h00);
    vec[14] = mk(12'h83F, 8'h3C, 17'h1ABCD, 8'h5A, 7'b0100000, 8'h77, 8'h00);
    vec[15] = mk(12'h83F, 8'h00, 17'h1ABCD, 8'h5A, 7'b1100001, 8'h77, 8'h3C);

    #1 reset = 1'b1;
    #1 chk("reset_async", 64'(obs()), 64'({17'h0, 8'h0, 7'b1100000, 8'h0, 8'h0}));
    repeat (2) @(posedge clk);
    #1 chk("reset_held", 64'({obs(), cpu_rdata}),
           64'({17'h0, 8'h0, 7'b1100000, 8'h0, 8'h0, 8'h0}));
    @(negedge clk) reset = 1'b0;

    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      chk($sformatf("frame0_clk%0d", k), 64'(obs()), 64'(vec[k].exp));
      video_addr  = vec[k].vaddr;
      ram_data_in = vec[k].rdin;
    end

    // video turned off mid-frame: slots 0/1 stay video until the next frame
    run_frame("f1_ven_off_mid", 1'b0, 8'h11, 16'h000F, 16'h00F0, 16'h0800, 16'h8000,
              16'h6066, 16'h0400);
    chk("f1_host_rdata", 64'(host_rdata), 64'(8'h11));
    run_frame("f2_host_video_slots", 1'b0, 8'hC3, 16'h0000, 16'h0000, 16'h0800, 16'h8088,
              16'h6066, 16'h0400);
    cpu_halt = 1'b1;
    host_we  = 1'b1;
    run_frame("f3_halt_host_write", 1'b0, 8'h44, 16'h0000, 16'h0000, 16'h0000, 16'h8888,
              16'h0000, 16'h4444);
    chk("f3_host_wdata", 64'({ram_data_out, host_rdata}), 64'({8'hC9, 8'hC3}));
    host_req = 1'b0;
    run_frame("f4_all_idle", 1'b0, 8'h55, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
              16'h0000, 16'h0000);
    video_en   = 1'b1;
    cpu_halt   = 1'b0;
    cpu_we     = 1'b0;
    cpu_addr   = 16'h0042;
    video_addr = 12'h005;
    run_frame("f5_cpu_read", 1'b1, 8'h99, 16'h000F, 16'h00F0, 16'h0800, 16'h0000,
              16'h0666, 16'h0000);
    chk("f5_read_data", 64'({cpu_rdata, video_data, host_rdata, ram_addr}),
        64'({8'h99, 8'h99, 8'hC3, 17'h00042}));

    // reset in the middle of a CPU write
    cpu_we = 1'b1;
    for (int p = 0; p <= 10; p++) begin
      @(posedge clk); #1;
    end
    chk("f6_we_low_c2", 64'(ram_we_n), 64'(1'b0));
    #2 reset = 1'b1;
    #1 chk("f6_reset_release_bus", 64'({ram_we_n, ram_oe_n, ram_data_oe}), 64'(3'b110));
    any_pulse = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      any_pulse = any_pulse | cpu_clk_en | host_ack;
    end
    chk("f6_no_pulse_in_reset", 64'(any_pulse), 64'(1'b0));
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    chk("f6_restart_c0", 64'({video_ram_strobe, ram_oe_n, ram_we_n, cpu_clk_en, ram_addr}),
        64'({4'b1110, 17'h0}));
    @(posedge clk); #1;
    chk("f6_restart_c1", 64'({ram_oe_n, ram_addr}), 64'({1'b0, 17'h08005}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
